// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard to Z88 key-matrix decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int         KBMAT_W = 64;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scancode ROM: {ext, code} -> Z88 matrix bit index (row*8+col).
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output logic [5:0] idx
);

    always_comb begin
        hit = 1'b1;
        idx = 6'd0;
        case ({ext, code})
            {1'b0, 8'h1C}: idx = 6'd51;  // A
            {1'b0, 8'h29}: idx = 6'd46;  // space
            {1'b0, 8'h5A}: idx = 6'd6;   // enter
            {1'b0, 8'h66}: idx = 6'd7;   // backspace -> del
            {1'b1, 8'h75}: idx = 6'd11;  // up
            {1'b1, 8'h72}: idx = 6'd10;  // down
            {1'b1, 8'h6B}: idx = 6'd9;   // left
            {1'b1, 8'h74}: idx = 6'd8;   // right
            default:       hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_keymat.sv
// PS/2 frame receiver and make/break decoder driving a 64-bit Z88 key matrix.
// Optional frame timeout is enabled by defining PS2_TIMEOUT_EN.
module ps2_keymat
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25175000,
    parameter int TIMEOUT_US = 2000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2clk,
    input  logic               ps2dat,
    output logic [KBMAT_W-1:0] kbmat_out,
    output logic               code_valid,
    output logic [7:0]         code,
    output logic               frame_err
);

    logic       ps2clk_p0, ps2clk_p1, ps2clk_p2;
    logic       ps2dat_p0, ps2dat_p1;
    logic       fall, bit_in;
    ps2_state_t state_q, state_d;
    logic [2:0] cnt_q;
    logic [7:0] shift_q;
    logic       par_ok_q, ext_q, brk_q;
    logic       byte_ok, err, timeout;
    logic       hit;
    logic [5:0] idx;

    // Synchronizer stages p0/p1; p2 only exists to see the falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2clk_p0 <= 1'b1;
            ps2clk_p1 <= 1'b1;
            ps2clk_p2 <= 1'b1;
            ps2dat_p0 <= 1'b1;
            ps2dat_p1 <= 1'b1;
        end else begin
            ps2clk_p0 <= ps2clk;
            ps2clk_p1 <= ps2clk_p0;
            ps2clk_p2 <= ps2clk_p1;
            ps2dat_p0 <= ps2dat;
            ps2dat_p1 <= ps2dat_p0;
        end
    end

    assign fall   = ps2clk_p2 & ~ps2clk_p1;
    assign bit_in = ps2dat_p1;

`ifdef PS2_TIMEOUT_EN
    localparam int TO_LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || state_q == ST_IDLE || fall)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 1'b1;
    end

    assign timeout = (state_q != ST_IDLE) && !fall && (to_cnt_q == TO_W'(TO_LIMIT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        byte_ok = 1'b0;
        err     = 1'b0;
        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bit_in) state_d = ST_DATA;
                    else         err     = 1'b1;
                end
                ST_DATA:   if (cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (bit_in && par_ok_q) byte_ok = 1'b1;
                    else                    err     = 1'b1;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
        if (timeout) begin
            state_d = ST_IDLE;
            err     = 1'b1;
        end
    end

    // Receive shift register carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (fall && state_q == ST_DATA)
            shift_q <= {bit_in, shift_q[7:1]};
    end

    ps2_keymap u_keymap (
        .ext  (ext_q),
        .code (shift_q),
        .hit  (hit),
        .idx  (idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            par_ok_q   <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            code       <= 8'h00;
            kbmat_out  <= '1;
        end else begin
            state_q    <= state_d;
            code_valid <= byte_ok;
            frame_err  <= err;
            if (fall) begin
                case (state_q)
                    ST_IDLE:   cnt_q    <= 3'd0;
                    ST_DATA:   cnt_q    <= cnt_q + 3'd1;
                    ST_PARITY: par_ok_q <= ^{bit_in, shift_q};
                    default:   ;
                endcase
            end
            // Prefixes arm ext/brk; any other byte consumes them.
            if (byte_ok) begin
                code <= shift_q;
                if (shift_q == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (shift_q == PS2_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    if (hit) kbmat_out[idx] <= brk_q;
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
            if (err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keymat.sv
// Directed bench for ps2_keymat: frames, prefixes, errors, reset abort, timeout.
module tb_ps2_keymat;

    localparam int HALF = 8;
    localparam logic [63:0] ALL_UP  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] A_DN    = 64'hFFF7_FFFF_FFFF_FFFF;
    localparam logic [63:0] UP_DN   = 64'hFFFF_FFFF_FFFF_F7FF;
    localparam logic [63:0] SPC_DN  = 64'hFFFF_BFFF_FFFF_FFFF;
    localparam logic [63:0] ENT_DN  = 64'hFFFF_FFFF_FFFF_FFBF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2clk = 1'b1;
    logic        ps2dat = 1'b1;
    logic [63:0] kbmat_out;
    logic        code_valid;
    logic [7:0]  code;
    logic        frame_err;

    int          nvec = 0;
    int          nbad = 0;
    int          n_valid = 0;
    int          n_err = 0;
    logic [7:0]  last_code = 8'h00;

    ps2_keymat #(.CLK_HZ(25175000), .TIMEOUT_US(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2dat     (ps2dat),
        .kbmat_out  (kbmat_out),
        .code_valid (code_valid),
        .code       (code),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid === 1'b1) begin
            n_valid   <= n_valid + 1;
            last_code <= code;
        end
        if (frame_err === 1'b1) n_err <= n_err + 1;
    end

    task automatic send_bit(input logic v);
        @(negedge clk) ps2dat = v;
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good_par);
        logic p;
        p = good_par ? ~^b : ^b;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk) reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nvec++; if (kbmat_out !== ALL_UP) begin nbad++; $display("FAIL reset_kbmat got=%h exp=%h", kbmat_out, ALL_UP); end
        nvec++; if (code !== 8'h00) begin nbad++; $display("FAIL reset_code got=%h exp=00", code); end
        nvec++; if (code_valid !== 1'b0) begin nbad++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
        nvec++; if (frame_err !== 1'b0) begin nbad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_make_break;
        int v0, lat;
        v0  = n_valid;
        lat = 0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h1C >> i) & 8'h01) != 0);
        send_bit(~^8'h1C);
        @(negedge clk) ps2dat = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (lat == 0 && code_valid === 1'b1) lat = k;
        end
        ps2clk = 1'b1;
        repeat (6) @(negedge clk);
        nvec++; if (lat < 2 || lat > 4) begin nbad++; $display("FAIL make_latency got=%0d exp=3+-1", lat); end
        nvec++; if (n_valid - v0 !== 1) begin nbad++; $display("FAIL make_strobes got=%0d exp=1", n_valid - v0); end
        nvec++; if (last_code !== 8'h1C) begin nbad++; $display("FAIL make_code got=%h exp=1c", last_code); end
        nvec++; if (kbmat_out !== A_DN) begin nbad++; $display("FAIL make_a got=%h exp=%h", kbmat_out, A_DN); end
        send_frame(8'hF0, 1'b1);
        nvec++; if (kbmat_out !== A_DN) begin nbad++; $display("FAIL brk_prefix got=%h exp=%h", kbmat_out, A_DN); end
        send_frame(8'h1C, 1'b1);
        nvec++; if (kbmat_out !== ALL_UP) begin nbad++; $display("FAIL break_a got=%h exp=%h", kbmat_out, ALL_UP); end
    endtask

    task automatic test_extended;
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        nvec++; if (kbmat_out !== UP_DN) begin nbad++; $display("FAIL ext_make_up got=%h exp=%h", kbmat_out, UP_DN); end
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h75, 1'b1);
        nvec++; if (kbmat_out !== ALL_UP) begin nbad++; $display("FAIL ext_break_up got=%h exp=%h", kbmat_out, ALL_UP); end
        send_frame(8'h75, 1'b1);
        nvec++; if (kbmat_out !== ALL_UP) begin nbad++; $display("FAIL bare_75 got=%h exp=%h", kbmat_out, ALL_UP); end
    endtask

    task automatic test_unmapped;
        send_frame(8'h1C, 1'b1);
        send_frame(8'hAA, 1'b1);
        send_frame(8'hFA, 1'b1);
        send_frame(8'hE1, 1'b1);
        nvec++; if (kbmat_out !== A_DN) begin nbad++; $display("FAIL unmapped got=%h exp=%h", kbmat_out, A_DN); end
        nvec++; if (last_code !== 8'hE1) begin nbad++; $display("FAIL unmapped_code got=%h exp=e1", last_code); end
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b1);
        nvec++; if (kbmat_out !== ALL_UP) begin nbad++; $display("FAIL unmapped_release got=%h exp=%h", kbmat_out, ALL_UP); end
    endtask

    task automatic test_parity;
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h29, 1'b0);
        nvec++; if (n_err - e0 !== 1) begin nbad++; $display("FAIL par_err got=%0d exp=1", n_err - e0); end
        nvec++; if (n_valid - v0 !== 0) begin nbad++; $display("FAIL par_novalid got=%0d exp=0", n_valid - v0); end
        nvec++; if (kbmat_out !== ALL_UP) begin nbad++; $display("FAIL par_kbmat got=%h exp=%h", kbmat_out, ALL_UP); end
        send_frame(8'h29, 1'b1);
        nvec++; if (kbmat_out !== SPC_DN) begin nbad++; $display("FAIL par_recover got=%h exp=%h", kbmat_out, SPC_DN); end
        // A bad frame after F0 must drop the break prefix, so 29 is a make.
        send_frame(8'hF0, 1'b1);
        send_frame(8'h11, 1'b0);
        send_frame(8'h29, 1'b1);
        nvec++; if (kbmat_out !== SPC_DN) begin nbad++; $display("FAIL err_clears_brk got=%h exp=%h", kbmat_out, SPC_DN); end
        send_frame(8'hF0, 1'b1);
        send_frame(8'h29, 1'b1);
        nvec++; if (kbmat_out !== ALL_UP) begin nbad++; $display("FAIL space_release got=%h exp=%h", kbmat_out, ALL_UP); end
    endtask

    task automatic test_start_err;
        int e0;
        e0 = n_err;
        send_bit(1'b1);
        repeat (6) @(negedge clk);
        nvec++; if (n_err - e0 !== 1) begin nbad++; $display("FAIL start_err got=%0d exp=1", n_err - e0); end
        send_frame(8'h5A, 1'b1);
        nvec++; if (kbmat_out !== ENT_DN) begin nbad++; $display("FAIL after_start_err got=%h exp=%h", kbmat_out, ENT_DN); end
    endtask

    task automatic test_idempotent;
        send_frame(8'h5A, 1'b1);
        nvec++; if (kbmat_out !== ENT_DN) begin nbad++; $display("FAIL repeat_make got=%h exp=%h", kbmat_out, ENT_DN); end
        send_frame(8'hF0, 1'b1);
        send_frame(8'h5A, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h5A, 1'b1);
        nvec++; if (kbmat_out !== ALL_UP) begin nbad++; $display("FAIL repeat_break got=%h exp=%h", kbmat_out, ALL_UP); end
    endtask

`ifdef PS2_TIMEOUT_EN
    task automatic test_timeout;
        int e0;
        e0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (700) @(negedge clk);
        nvec++; if (n_err - e0 !== 1) begin nbad++; $display("FAIL timeout_err got=%0d exp=1", n_err - e0); end
        send_frame(8'h5A, 1'b1);
        nvec++; if (kbmat_out !== ENT_DN) begin nbad++; $display("FAIL timeout_recover got=%h exp=%h", kbmat_out, ENT_DN); end
        send_frame(8'hF0, 1'b1);
        send_frame(8'h5A, 1'b1);
    endtask
`endif

    task automatic test_reset_mid;
        int v0, e0;
        send_frame(8'h5A, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        v0 = n_valid;
        e0 = n_err;
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        nvec++; if ((n_valid - v0) + (n_err - e0) !== 0) begin nbad++; $display("FAIL midreset_strobe got=%0d exp=0", (n_valid - v0) + (n_err - e0)); end
        nvec++; if (kbmat_out !== ALL_UP) begin nbad++; $display("FAIL midreset_kbmat got=%h exp=%h", kbmat_out, ALL_UP); end
        send_frame(8'h1C, 1'b1);
        nvec++; if (kbmat_out !== A_DN) begin nbad++; $display("FAIL midreset_recover got=%h exp=%h", kbmat_out, A_DN); end
    endtask

    initial begin
        test_reset;
        test_make_break;
        test_extended;
        test_unmapped;
        test_parity;
        test_start_err;
        test_idempotent;
`ifdef PS2_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/ps2_keymat.md
PS2_KEYMAT -- requirements
Module: ps2_keymat

Interface
REQ-001 Parameter: CLK_HZ, 25175000, system clock frequency used to derive the timeout count.
REQ-002 Parameter: TIMEOUT_US, 2000, maximum time between PS/2 clock falling edges inside one frame.
REQ-003 Port: clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: ps2clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-006 Port: ps2dat  input  1  raw PS/2 data, asynchronous to clk.
REQ-007 Port: kbmat_out  output  64  Z88 key matrix, bit = row*8+col; 0 = pressed, 1 = released.
REQ-008 Port: code_valid  output  1  one-cycle strobe for each good received byte.
REQ-009 Port: code  output  8  last good byte; valid while code_valid is high.
REQ-010 Port: frame_err  output  1  one-cycle strobe on parity, start, stop or timeout error.

Function
REQ-011 ps2clk and ps2dat SHALL each pass through a 2-flop synchronizer; a PS/2 falling edge SHALL be detected from a third register stage.
REQ-012 Frame FSM states SHALL be IDLE, DATA, PARITY and STOP; each transition SHALL occur only on a detected falling edge.
REQ-013 IDLE: when ps2dat=0, go to DATA with the bit count cleared; when ps2dat=1, treat the edge as a start error, stay in IDLE and pulse frame_err.
REQ-014 DATA: shift data in LSB first; after 8 bits go to PARITY.
REQ-015 PARITY: the 9 bits (data plus parity) SHALL have odd parity; otherwise flag an error and still go to STOP.
REQ-016 STOP: when ps2dat=1 and parity is good, pulse code_valid with code updated in the same cycle; otherwise pulse frame_err. In both cases return to IDLE.
REQ-017 Latency: code_valid SHALL assert 3 clk cycles (±1) after the raw stop-bit falling edge.
REQ-018 Decoder prefixes: byte 0xE0 sets ext; byte 0xF0 sets brk. Neither prefix changes kbmat_out.
REQ-019 Any other good byte SHALL be looked up using {ext, byte}. On a hit, bit idx is cleared (make) or set (brk=1). ext and brk SHALL then be cleared whether or not the lookup hit.
REQ-020 Unmapped codes, including 0xAA, 0xFA and 0xE1, SHALL leave kbmat_out unchanged.
REQ-021 On any frame_err, ext and brk SHALL be cleared and kbmat_out SHALL be unchanged.
REQ-022 A repeated make of a held key SHALL be idempotent; a break for an unpressed key SHALL be idempotent.
REQ-023 kbmat_out SHALL be registered; at most one bit SHALL change per clk cycle.

Reset
REQ-024 On reset, the FSM SHALL go to IDLE and bit count, ext, brk, code_valid and frame_err SHALL be 0.
REQ-025 On reset, code SHALL be 0x00 and kbmat_out SHALL be all ones (all keys released).
REQ-026 Reset asserted mid-frame SHALL abort the frame with no strobe; reception SHALL restart on the next start bit after release.

Configuration
REQ-027 Macro PS2_TIMEOUT_EN: when defined, a counter SHALL run in every non-IDLE state and SHALL clear on each falling edge.
REQ-028 Timeout limit: reaching CLK_HZ/1000000*TIMEOUT_US cycles SHALL force IDLE, pulse frame_err and clear prefixes.
REQ-029 Without PS2_TIMEOUT_EN, no counter SHALL be synthesized and a stalled frame SHALL wait indefinitely.

Structure
REQ-030 Shared package ps2_pkg SHALL hold the FSM state enum, constants PS2_EXT=0xE0 and PS2_BRK=0xF0, and the kbmat width of 64.
REQ-031 Sub-module ps2_keymap SHALL be a combinational ROM: input {ext, code[7:0]}, outputs hit and idx[5:0].
REQ-032 Keymap entries fixed for verification: 0x1C→idx 51 (A), 0x29→idx 46 (space), 0x5A→idx 6 (enter), {1,0x75}→idx 11 (up).

Verification
REQ-033 Reset, then frame 0x1C with good parity → code_valid=1, code=0x1C, kbmat_out[51]=0, all other bits 1.
REQ-034 Then frames F0,1C → kbmat_out[51]=1 and kbmat_out=64'hFFFF_FFFF_FFFF_FFFF.
REQ-035 Frames E0,75 → bit 11 cleared; then E0,F0,75 → bit 11 set; a bare 0x75 → no change.
REQ-036 Frame 0x29 with wrong parity → frame_err=1, no code_valid, kbmat_out[46] stays 1; next good 0x29 → bit 46 cleared.
REQ-037 With PS2_TIMEOUT_EN, stop ps2clk after 4 data bits for > TIMEOUT_US → frame_err=1 and FSM in IDLE; a following good 0x5A → bit 6 cleared.
REQ-038 Assert reset after the 5th bit of a frame → no strobe and kbmat_out all ones; a following full 0x1C → bit 51 cleared.
